uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer between the UART receiver's deserialiser and the host/testbench read port. Captures each received character with its 3-bit error status, presents the oldest entry in first-word-fall-through form on `Data_Out`/`Rx_Error`, and pops on `Read_Done`. Reports empty/full/overflow and drives the `RTS` flow-control line from its fill level.

## Interface
- `DATA_BITS`, 8: character width.
- `FIFO_DEPTH`, 8: entries; power of two, ≥ 4.
- `RTS_OFF_LEVEL`, FIFO_DEPTH-2: fill count at or above which RTS deasserts.
- `RTS_ON_LEVEL`, FIFO_DEPTH/2: fill count at or below which RTS reasserts; must be < RTS_OFF_LEVEL.
- `SysClk` in 1: system clock, all logic on rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Wr_En` in 1: one-cycle strobe from the receiver; character complete.
- `Wr_Data` in DATA_BITS: received character, valid with `Wr_En`.
- `Wr_Error` in 3: receiver status with `Wr_En`; [0] parity, [1] framing, [2] break.
- `Read_Done` in 1: consumer pop strobe.
- `Overflow_Clr` in 1: clears sticky overflow.
- `Data_Out` out DATA_BITS: head character.
- `Rx_Error` out 3: head entry's error status.
- `Data_Rdy` out 1: head valid (= !FIFO_Empty).
- `FIFO_Empty` out 1: no entries.
- `FIFO_Full` out 1: count == FIFO_DEPTH.
- `FIFO_Overflow` out 1: sticky; a write was dropped.
- `Fill_Count` out $clog2(FIFO_DEPTH+1): current entries.
- `RTS` out 1: high = peer may send.

## Operation
- Storage: FIFO_DEPTH × (DATA_BITS+3). Write/read pointers are $clog2(FIFO_DEPTH) bits, wrap naturally modulo depth; separate count register, no pointer-compare ambiguity.
- Push when `Wr_En && (!FIFO_Full || Read_Done)`; pop when `Read_Done && !FIFO_Empty`.
- Full + `Wr_En` + `Read_Done` same cycle: pop and push both occur, count unchanged, no overflow.
- Empty + `Wr_En` + `Read_Done`: push only; `Read_Done` ignored.
- `Read_Done` on empty: ignored, no flag, pointers unchanged.
- Full + `Wr_En`, no `Read_Done`: character discarded, contents intact, `FIFO_Overflow` set.
- `FIFO_Overflow` cleared by `Overflow_Clr`; if clear and a new overflow coincide, set wins.
- RTS FSM, two states: RTS_ASSERT (RTS=1) → RTS_HOLD when next count ≥ RTS_OFF_LEVEL; RTS_HOLD (RTS=0) → RTS_ASSERT when next count ≤ RTS_ON_LEVEL. Hysteresis prevents toggling per character.
- `Rx_Error` is stored per entry and read independently of data; no error causes rejection.

## Timing
- Reset values: `Data_Out`=0, `Rx_Error`=0, `Data_Rdy`=0, `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0, `Fill_Count`=0, `RTS`=1, FSM=RTS_ASSERT, pointers 0.
- Reset mid-operation discards all contents immediately (asynchronous); outputs at reset values while `Rst` high.
- Write latency: `Wr_En` at edge N → `Data_Out` valid, `FIFO_Empty`=0, `Data_Rdy`=1 after edge N+1 (registered, one cycle).
- Pop: `Read_Done` at edge N → next entry on `Data_Out` after edge N; if last entry, `FIFO_Empty`=1 after edge N.
- All status outputs and `RTS` registered; `RTS` changes on the same edge as the count crossing its threshold.
- `Data_Out` undefined-but-stable (holds last value) while empty; consumers qualify with `Data_Rdy`.

## Configuration
- `UART_RX_FIFO_RTS_EN` defined: RTS FSM and hysteresis as above.
- Not defined: FSM and thresholds removed; `RTS` tied to 1; RTS parameters unused.

## Structure
- Shared package `uart_pkg`: `rx_error_t` (3-bit packed struct parity/framing/break), `rx_fifo_entry_t` (data + rx_error_t), RTS FSM state enum.
- Sub-module `uart_fifo_ram`: plain dual-pointer storage array (one write port, one asynchronous read port); control, count, flags and RTS FSM remain in `uart_rx_fifo`.

## Test plan
- Write 0x41, 0x42, 0x43 on consecutive cycles → `Data_Out`=0x41 one cycle after first write, `Fill_Count`=3; three pops return 0x41/0x42/0x43 then `FIFO_Empty`=1.
- Write 9 characters 0x00–0x08 into depth 8, no reads → `FIFO_Full`=1 after 8th, `FIFO_Overflow`=1 after 9th; drain returns 0x00–0x07, 0x08 absent; `Overflow_Clr` → 0.
- Full FIFO, `Wr_En`(0xAA) and `Read_Done` same cycle → count stays 8, no overflow, 0xAA is last read out.
- Write 0x55 with `Wr_Error`=3'b010 → `Rx_Error`=3'b010 at head; next entry 0x56 with 3'b000 shows `Rx_Error`=0 after pop.
- RTS_EN build, depth 8: fill to 6 → `RTS`=0 on that edge; pop to 5 → still 0; pop to 4 → `RTS`=1.
- Assert `Rst` asynchronously with 5 entries → outputs at reset values without a clock edge; subsequent write of 0x11 reads back 0x11.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: per-character error status,
// FIFO entry layout and the RTS flow-control FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef struct packed {
        logic brk;
        logic framing;
        logic parity;
    } rx_error_t;

    typedef struct packed {
        logic [UART_DATA_BITS-1:0] data;
        rx_error_t                 error;
    } rx_fifo_entry_t;

    typedef enum logic [0:0] {
        RTS_ASSERT = 1'b0,
        RTS_HOLD   = 1'b1
    } rts_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port. Holds no control state of its own.
module uart_fifo_ram #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word-fall-through head register, sticky overflow
// and RTS flow control (hysteresis FSM only when UART_RX_FIFO_RTS_EN is defined).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned RTS_OFF_LEVEL = FIFO_DEPTH - 2,
    parameter int unsigned RTS_ON_LEVEL  = FIFO_DEPTH / 2
) (
    input  logic                            SysClk,
    input  logic                            Rst,
    input  logic                            Wr_En,
    input  logic [DATA_BITS-1:0]            Wr_Data,
    input  logic [2:0]                      Wr_Error,
    input  logic                            Read_Done,
    input  logic                            Overflow_Clr,
    output logic [DATA_BITS-1:0]            Data_Out,
    output logic [2:0]                      Rx_Error,
    output logic                            Data_Rdy,
    output logic                            FIFO_Empty,
    output logic                            FIFO_Full,
    output logic                            FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] Fill_Count,
    output logic                            RTS
);

    localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_BITS = DATA_BITS + 3;

    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   rd_ptr_next;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   count_next;
    logic                  push;
    logic                  pop;
    rx_error_t             wr_status;
    logic [ENTRY_BITS-1:0] wr_entry;
    logic [ENTRY_BITS-1:0] ram_rd_data;
    logic [ENTRY_BITS-1:0] head_next;

    assign push        = Wr_En && (!FIFO_Full || Read_Done);
    assign pop         = Read_Done && !FIFO_Empty;
    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign wr_status   = rx_error_t'(Wr_Error);
    assign wr_entry    = {Wr_Data, wr_status};

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    uart_fifo_ram #(
        .WIDTH     (ENTRY_BITS),
        .DEPTH     (FIFO_DEPTH),
        .ADDR_BITS (PTR_BITS)
    ) u_ram (
        .clk     (SysClk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_next),
        .rd_data (ram_rd_data)
    );

    // The new head is the incoming character when it lands in the slot the
    // read pointer is about to reference (empty FIFO, or last entry popped).
    assign head_next = (push && (rd_ptr_next == wr_ptr)) ? wr_entry : ram_rd_data;

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_Empty    <= 1'b1;
            FIFO_Full     <= 1'b0;
            FIFO_Overflow <= 1'b0;
            Data_Out      <= '0;
            Rx_Error      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            FIFO_Empty <= (count_next == '0);
            FIFO_Full  <= (count_next == CNT_BITS'(FIFO_DEPTH));
            if (Wr_En && !push) begin
                FIFO_Overflow <= 1'b1;
            end else if (Overflow_Clr) begin
                FIFO_Overflow <= 1'b0;
            end
            if (count_next != '0) begin
                Data_Out <= head_next[ENTRY_BITS-1:3];
                Rx_Error <= head_next[2:0];
            end
        end
    end

    assign Data_Rdy   = !FIFO_Empty;
    assign Fill_Count = count;

`ifdef UART_RX_FIFO_RTS_EN
    rts_state_t rts_state;
    rts_state_t rts_state_next;

    // Thresholds are evaluated on the post-edge count so RTS moves on the
    // same edge that crosses the level.
    always_comb begin
        rts_state_next = rts_state;
        case (rts_state)
            RTS_ASSERT: if (count_next >= CNT_BITS'(RTS_OFF_LEVEL)) rts_state_next = RTS_HOLD;
            RTS_HOLD:   if (count_next <= CNT_BITS'(RTS_ON_LEVEL))  rts_state_next = RTS_ASSERT;
            default:    rts_state_next = RTS_ASSERT;
        endcase
    end

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            rts_state <= RTS_ASSERT;
        end else begin
            rts_state <= rts_state_next;
        end
    end

    assign RTS = (rts_state == RTS_ASSERT);
`else
    logic unused_rts_cfg;
    assign unused_rts_cfg = (RTS_ON_LEVEL < RTS_OFF_LEVEL);
    assign RTS            = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 8;
    localparam int OFF   = DEPTH - 2;
    localparam int ON    = DEPTH / 2;
`ifdef UART_RX_FIFO_RTS_EN
    localparam bit RTS_EN = 1'b1;
`else
    localparam bit RTS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DB-1:0] wr_data = '0;
    logic [2:0]    wr_err = '0;
    logic          rd = 1'b0;
    logic          clr = 1'b0;
    logic [DB-1:0] data_out;
    logic [2:0]    rx_error;
    logic          data_rdy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_overflow;
    logic [3:0]    fill_count;
    logic          rts;

    uart_rx_fifo #(
        .DATA_BITS     (DB),
        .FIFO_DEPTH    (DEPTH),
        .RTS_OFF_LEVEL (OFF),
        .RTS_ON_LEVEL  (ON)
    ) dut (
        .SysClk        (clk),
        .Rst           (rst),
        .Wr_En         (wr_en),
        .Wr_Data       (wr_data),
        .Wr_Error      (wr_err),
        .Read_Done     (rd),
        .Overflow_Clr  (clr),
        .Data_Out      (data_out),
        .Rx_Error      (rx_error),
        .Data_Rdy      (data_rdy),
        .FIFO_Empty    (fifo_empty),
        .FIFO_Full     (fifo_full),
        .FIFO_Overflow (fifo_overflow),
        .Fill_Count    (fill_count),
        .RTS           (rts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {data, error}, overflow flag, RTS level.
    logic [DB+2:0] sb[$];
    bit            ovf_exp = 1'b0;
    bit            rts_exp = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            ovf_exp = 1'b0;
            rts_exp = 1'b1;
        end else begin
            if (clr) ovf_exp = 1'b0;
            if (wr_en) begin
                if (sb.size() < DEPTH) sb.push_back({wr_data, wr_err});
                else ovf_exp = 1'b1;
            end
            if (RTS_EN) begin
                if (rts_exp && sb.size() >= OFF) rts_exp = 1'b0;
                else if (!rts_exp && sb.size() <= ON) rts_exp = 1'b1;
            end
        end
    end

    // Monitor: compares status and head each cycle, pops on consumer read.
    always @(negedge clk) begin
        if (!rst) begin
            chk("fill_count", 32'(fill_count), sb.size());
            chk("fifo_empty", 32'(fifo_empty), 32'(sb.size() == 0));
            chk("fifo_full", 32'(fifo_full), 32'(sb.size() == DEPTH));
            chk("data_rdy", 32'(data_rdy), 32'(sb.size() != 0));
            chk("overflow", 32'(fifo_overflow), 32'(ovf_exp));
            chk("rts", 32'(rts), 32'(rts_exp));
            if (sb.size() > 0) begin
                chk("data_out", 32'(data_out), 32'(sb[0][DB+2:3]));
                chk("rx_error", 32'(rx_error), 32'(sb[0][2:0]));
                if (rd) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input bit w, input logic [DB-1:0] d, input logic [2:0] e,
                        input bit r, input bit c);
        @(posedge clk);
        #1;
        wr_en = w; wr_data = d; wr_err = e; rd = r; clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 0);
        chk({tag, "_rx_error"}, 32'(rx_error), 0);
        chk({tag, "_data_rdy"}, 32'(data_rdy), 0);
        chk({tag, "_empty"}, 32'(fifo_empty), 1);
        chk({tag, "_full"}, 32'(fifo_full), 0);
        chk({tag, "_overflow"}, 32'(fifo_overflow), 0);
        chk({tag, "_fill"}, 32'(fill_count), 0);
        chk({tag, "_rts"}, 32'(rts), 1);
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Three characters in, three out.
        step(1'b1, 8'h41, 3'b000, 1'b0, 1'b0);
        step(1'b1, 8'h42, 3'b000, 1'b0, 1'b0);
        step(1'b1, 8'h43, 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("abc_fill", 32'(fill_count), 3);
        chk("abc_head", 32'(data_out), 32'h41);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        chk("abc_empty", 32'(fifo_empty), 1);

        // Overflow: ninth character dropped.
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("ovf_full", 32'(fifo_full), 1);
        chk("ovf_set", 32'(fifo_overflow), 1);
        repeat (DEPTH) step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        chk("ovf_drained", 32'(fifo_empty), 1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(1);
        chk("ovf_cleared", 32'(fifo_overflow), 0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 3'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 3'b000, 1'b1, 1'b0);
        idle(1);
        chk("fullrw_fill", 32'(fill_count), DEPTH);
        chk("fullrw_ovf", 32'(fifo_overflow), 0);
        repeat (DEPTH - 1) step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        chk("fullrw_last", 32'(data_out), 32'hAA);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // Error status travels with its character.
        step(1'b1, 8'h55, 3'b010, 1'b0, 1'b0);
        step(1'b1, 8'h56, 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("err_head", 32'(rx_error), 32'b010);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        chk("err_next_data", 32'(data_out), 32'h56);
        chk("err_next_status", 32'(rx_error), 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // RTS hysteresis around the fill thresholds.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("rts_at5", 32'(rts), 1);
        step(1'b1, 8'h65, 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("rts_at6", 32'(rts), RTS_EN ? 0 : 1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        chk("rts_back5", 32'(rts), RTS_EN ? 0 : 1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);
        chk("rts_back4", 32'(rts), 1);
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // Asynchronous reset with contents present.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 3'b111, 1'b0, 1'b0);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h11, 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("post_rst_data", 32'(data_out), 32'h11);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // Randomized traffic with varying write/read pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            int pr;
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
            pr = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 75 : 50;
            repeat (400) begin
                step($urandom_range(0, 99) < pw, 8'($urandom), 3'($urandom),
                     $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3);
            end
        end
        repeat (DEPTH + 2) step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(2);
        chk("final_empty", 32'(fifo_empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
